// File: rtl/imem_fetch_unit.sv
// imem_fetch_unit: fetches one 32-bit instruction as four byte beats from a
// byte-wide memory, big-endian, flagging misaligned requests and stalled memory.
module imem_fetch_unit #(
  parameter int WAIT_LIMIT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [0:31] req_addr,
  output logic        req_ready,
  output logic        mem_rd,
  output logic [0:31] mem_addr,
  input  logic [0:7]  mem_rdata,
  input  logic        mem_ack,
  output logic        rsp_valid,
  output logic [0:31] rsp_instr,
  output logic [0:31] rsp_addr,
  output logic        rsp_misaligned,
  output logic        rsp_timeout,
  input  logic        rsp_ready
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    RESP
  } state_e;

  localparam logic [7:0] WaitLast = 8'(WAIT_LIMIT - 1);

  state_e      state_q;
  logic [1:0]  beat_q;
  logic [7:0]  wait_q;
  logic        req_ready_q;
  logic        mem_rd_q;
  logic [0:31] mem_addr_q;
  logic        rsp_valid_q;
  logic [0:31] rsp_instr_q;
  logic [0:31] rsp_addr_q;
  logic        rsp_mis_q;
  logic        rsp_tmo_q;

  logic        beat_last;
  logic        wait_last;
  logic        misaligned;
  logic [0:31] next_addr;

  assign beat_last  = (beat_q == 2'd3);
  assign wait_last  = (wait_q == WaitLast);
  assign misaligned = (req_addr[30:31] != 2'b00);
  assign next_addr  = rsp_addr_q + {30'd0, beat_q} + 32'd1;

  // First FETCH cycle only raises the strobe; acks count once mem_rd is up.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      beat_q      <= '0;
      wait_q      <= '0;
      req_ready_q <= 1'b1;
      mem_rd_q    <= 1'b0;
      mem_addr_q  <= '0;
      rsp_valid_q <= 1'b0;
      rsp_instr_q <= '0;
      rsp_addr_q  <= '0;
      rsp_mis_q   <= 1'b0;
      rsp_tmo_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (req_valid) begin
            req_ready_q <= 1'b0;
            rsp_addr_q  <= req_addr;
            rsp_instr_q <= '0;
            beat_q      <= '0;
            wait_q      <= '0;
            if (misaligned) begin
              state_q     <= RESP;
              rsp_valid_q <= 1'b1;
              rsp_mis_q   <= 1'b1;
            end else begin
              state_q <= FETCH;
            end
          end
        end
        FETCH: begin
          unique case (1'b1)
            !mem_rd_q: begin
              mem_rd_q   <= 1'b1;
              mem_addr_q <= rsp_addr_q;
            end
            mem_rd_q && mem_ack: begin
              rsp_instr_q[{beat_q, 3'b000} +: 8] <= mem_rdata;
              wait_q <= '0;
              if (beat_last) begin
                state_q     <= RESP;
                mem_rd_q    <= 1'b0;
                rsp_valid_q <= 1'b1;
              end else begin
                beat_q     <= beat_q + 2'd1;
                mem_addr_q <= next_addr;
              end
            end
            mem_rd_q && !mem_ack && wait_last: begin
              state_q     <= RESP;
              mem_rd_q    <= 1'b0;
              rsp_valid_q <= 1'b1;
              rsp_tmo_q   <= 1'b1;
              rsp_instr_q <= '0;
            end
            mem_rd_q && !mem_ack && !wait_last: begin
              wait_q <= wait_q + 8'd1;
            end
            default: ;
          endcase
        end
        RESP: begin
          if (rsp_ready) begin
            state_q     <= IDLE;
            rsp_valid_q <= 1'b0;
            rsp_mis_q   <= 1'b0;
            rsp_tmo_q   <= 1'b0;
            req_ready_q <= 1'b1;
          end
        end
        default: begin
          state_q     <= IDLE;
          req_ready_q <= 1'b1;
          mem_rd_q    <= 1'b0;
          rsp_valid_q <= 1'b0;
          rsp_mis_q   <= 1'b0;
          rsp_tmo_q   <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready      = req_ready_q;
  assign mem_rd         = mem_rd_q;
  assign mem_addr       = mem_addr_q;
  assign rsp_valid      = rsp_valid_q;
  assign rsp_instr      = rsp_instr_q;
  assign rsp_addr       = rsp_addr_q;
  assign rsp_misaligned = rsp_mis_q;
  assign rsp_timeout    = rsp_tmo_q;

`ifndef SYNTHESIS
  a_flags_excl: assert property (@(posedge clk) disable iff (!reset)
    !(rsp_misaligned && rsp_timeout));
  a_ready_idle: assert property (@(posedge clk) disable iff (!reset)
    req_ready == (state_q == IDLE));
`endif

endmodule

// File: tb/tb_imem_fetch_unit.sv
// tb_imem_fetch_unit: random and directed fetches checked against a
// transaction-level model of the byte memory and ack/stall rules.
module tb_imem_fetch_unit;

  localparam int WL = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic [0:31] req_addr;
  logic        req_ready;
  logic        mem_rd;
  logic [0:31] mem_addr;
  logic [0:7]  mem_rdata;
  logic        mem_ack;
  logic        rsp_valid;
  logic [0:31] rsp_instr;
  logic [0:31] rsp_addr;
  logic        rsp_misaligned;
  logic        rsp_timeout;
  logic        rsp_ready;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] mem_ov [logic [31:0]];

  always #5 clk = ~clk;

  imem_fetch_unit #(.WAIT_LIMIT(WL)) dut (
    .clk            (clk),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_addr       (req_addr),
    .req_ready      (req_ready),
    .mem_rd         (mem_rd),
    .mem_addr       (mem_addr),
    .mem_rdata      (mem_rdata),
    .mem_ack        (mem_ack),
    .rsp_valid      (rsp_valid),
    .rsp_instr      (rsp_instr),
    .rsp_addr       (rsp_addr),
    .rsp_misaligned (rsp_misaligned),
    .rsp_timeout    (rsp_timeout),
    .rsp_ready      (rsp_ready)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] mbyte(input logic [31:0] a);
    if (mem_ov.exists(a)) return mem_ov[a];
    return (a[7:0] * 8'd37) ^ a[15:8] ^ a[31:24] ^ 8'hA5;
  endfunction

  // 0 always, 1 never, 2 every other, 3 random, 4 WL-1 stalls per beat,
  // 5 first beat then stuck
  function automatic bit ack_for(input int mode, input int idx);
    case (mode)
      0: return 1'b1;
      1: return 1'b0;
      2: return idx[0];
      3: return $urandom_range(0, 99) < 60;
      4: return (idx % WL) == WL - 1;
      default: return idx == 0;
    endcase
  endfunction

  task automatic chk_reset(input string tag);
    chk({tag, "_req_ready"}, req_ready, 1);
    chk({tag, "_mem_rd"}, mem_rd, 0);
    chk({tag, "_mem_addr"}, mem_addr, 0);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_rsp_instr"}, rsp_instr, 0);
    chk({tag, "_rsp_addr"}, rsp_addr, 0);
    chk({tag, "_mis"}, rsp_misaligned, 0);
    chk({tag, "_tmo"}, rsp_timeout, 0);
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge, idle.
  task automatic run_txn(input logic [31:0] a, input int mode,
                         input int hold, output logic [31:0] got);
    logic [31:0] exp_w;
    logic [31:0] exp_i;
    bit          mis;
    bit          done;
    bit          tmo;
    bit          seen;
    bit          ack;
    int          beats;
    int          misses;
    int          k_done;
    int          rd_idx;
    chk("req_ready_idle", req_ready, 1);
    req_valid = 1'b1;
    req_addr  = a;
    mis = (a[1:0] != 2'b00);
    @(negedge clk);
    req_valid = 1'b0;
    beats = 0; misses = 0; done = mis; tmo = 0;
    k_done = -1; exp_w = 0; rd_idx = 0; seen = 0;
    for (int k = 0; k < 100 && !seen; k++) begin
      if (k > 0) @(negedge clk);
      if (rsp_valid) begin
        seen = 1;
        chk("rsp_latency", k, k_done + 1);
      end else begin
        chk("mem_rd", mem_rd, (!done && k > 0));
        if (mem_rd) chk("mem_addr", mem_addr, a + beats);
        if (mem_rd && !done) begin
          ack = ack_for(mode, rd_idx);
          rd_idx++;
          mem_ack   = ack;
          mem_rdata = ack ? mbyte(mem_addr) : 8'($urandom);
          if (ack) begin
            exp_w[31 - 8 * beats -: 8] = mbyte(a + beats);
            beats++;
            misses = 0;
            if (beats == 4) begin done = 1; k_done = k; end
          end else begin
            misses++;
            if (misses == WL) begin done = 1; tmo = 1; k_done = k; end
          end
        end else begin
          mem_ack   = 1'($urandom_range(0, 1));
          mem_rdata = 8'($urandom);
        end
        req_valid = ($urandom_range(0, 3) == 0);
        req_addr  = $urandom;
      end
    end
    got = rsp_instr;
    if (!seen) begin
      chk("rsp_seen", 0, 1);
      req_valid = 0; mem_ack = 0;
      #2 reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      return;
    end
    exp_i = (mis || tmo) ? 32'h0 : exp_w;
    chk("rsp_addr", rsp_addr, a);
    chk("rsp_instr", rsp_instr, exp_i);
    chk("rsp_mis", rsp_misaligned, mis);
    chk("rsp_tmo", rsp_timeout, tmo);
    chk("rsp_req_ready", req_ready, 0);
    for (int h = 0; h < hold; h++) begin
      req_valid = h[0] | 1'($urandom_range(0, 1));
      req_addr  = $urandom & 32'hFFFF_FFFC;
      mem_ack   = 1'($urandom_range(0, 1));
      mem_rdata = 8'($urandom);
      @(negedge clk);
      chk("hold_valid", rsp_valid, 1);
      chk("hold_instr", rsp_instr, exp_i);
      chk("hold_addr", rsp_addr, a);
      chk("hold_mis", rsp_misaligned, mis);
      chk("hold_tmo", rsp_timeout, tmo);
      chk("hold_req_ready", req_ready, 0);
      chk("hold_mem_rd", mem_rd, 0);
    end
    rsp_ready = 1'b1;
    req_valid = 1'($urandom_range(0, 1));
    req_addr  = $urandom & 32'hFFFF_FFFC;
    @(negedge clk);
    rsp_ready = 1'b0;
    req_valid = 1'b0;
    mem_ack   = 1'b0;
    chk("rel_valid", rsp_valid, 0);
    chk("rel_req_ready", req_ready, 1);
    chk("rel_mis", rsp_misaligned, 0);
    chk("rel_tmo", rsp_timeout, 0);
    chk("rel_mem_rd", mem_rd, 0);
  endtask

  task automatic reset_mid(input logic [31:0] a);
    chk("rm_req_ready", req_ready, 1);
    req_valid = 1'b1;
    req_addr  = a;
    @(negedge clk);
    req_valid = 1'b0;
    mem_ack   = 1'b0;
    @(negedge clk);
    chk("rm_mem_rd", mem_rd, 1);
    mem_ack   = 1'b1;
    mem_rdata = mbyte(mem_addr);
    @(negedge clk);
    mem_rdata = mbyte(mem_addr);
    @(negedge clk);
    chk("rm_beat2_addr", mem_addr, a + 2);
    mem_ack = 1'b0;
    #2 reset = 1'b0;
    #1 chk_reset("rm");
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      mem_ack = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("rm_no_rsp", rsp_valid, 0);
      chk("rm_idle", req_ready, 1);
      chk("rm_no_rd", mem_rd, 0);
    end
    mem_ack = 1'b0;
  endtask

  initial begin
    #10_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] got;
    logic [31:0] a;
    int          r;
    reset = 1'b1; req_valid = 0; req_addr = 0;
    mem_ack = 0; mem_rdata = 0; rsp_ready = 0;
    mem_ov[32'h40] = 8'h8C;
    mem_ov[32'h41] = 8'h22;
    mem_ov[32'h42] = 8'h00;
    mem_ov[32'h43] = 8'h10;
    #2 reset = 1'b0;
    #1 chk_reset("por");
    @(negedge clk);
    reset = 1'b1;
    run_txn(32'h0000_0040, 0, 2, got);
    chk("word_0x40", got, 32'h8C22_0010);
    run_txn(32'h0000_0042, 0, 1, got);
    run_txn(32'h0000_0100, 1, 1, got);
    run_txn(32'hFFFF_FFFC, 2, 1, got);
    run_txn(32'h0000_0200, 3, 10, got);
    run_txn(32'h0000_0300, 4, 1, got);
    run_txn(32'h0000_0400, 5, 1, got);
    reset_mid(32'h0000_0080);
    run_txn(32'h0000_0080, 0, 0, got);
    for (int t = 0; t < 150; t++) begin
      r = $urandom_range(0, 9);
      a = $urandom;
      if (r < 2) a[1:0] = 2'($urandom_range(1, 3));
      else if (r == 2) a = 32'hFFFF_FFFC;
      else a[1:0] = 2'b00;
      run_txn(a, $urandom_range(0, 5), $urandom_range(0, 4), got);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
